// File: rtl/eth_downlink_port.sv
// -----------------------------------------------------------------------------
// eth_downlink_port
// Receive-side steering port for the 10G Ethernet RX stream (data clock domain).
// Each frame is classified from its second beat (EtherType + SSR type byte) and
// routed to exactly one of three AXIS outputs: ctrl, data or forward. Runt
// frames (tlast on the first beat) and unrecognised frames are drained and
// counted in a saturating drop counter.
//
// The first two beats are held in H0/H1 until the header is known. They are
// then replayed (OUT0, OUT1) and the remainder of the frame is passed through
// combinationally (PASS).
//
// Ports
//   i_data_clk, i_data_rst : clock, asynchronous active-high reset
//   s_rx_axis_*            : RX frame stream in (tuser=1 on last beat = MAC error)
//   m_ctrl_axis_*          : ctrl frames out (sink always accepts, no tready)
//   m_data_axis_*          : data frames out, with tready
//   m_forward_axis_*       : forward frames out, with tready
//   o_drop_cnt             : dropped-frame count, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module eth_downlink_port #(
  parameter logic [15:0] P_ETH_TYPE  = 16'h88B5,
  parameter logic [7:0]  P_TYPE_CTRL = 8'h01,
  parameter logic [7:0]  P_TYPE_DATA = 8'h02,
  parameter logic [7:0]  P_TYPE_FWD  = 8'h03
) (
  input  logic        i_data_clk,
  input  logic        i_data_rst,
  input  logic        s_rx_axis_tvalid,
  input  logic [63:0] s_rx_axis_tdata,
  input  logic        s_rx_axis_tlast,
  input  logic [7:0]  s_rx_axis_tkeep,
  input  logic        s_rx_axis_tuser,
  output logic        s_rx_axis_tready,
  output logic        m_ctrl_axis_tvalid,
  output logic [63:0] m_ctrl_axis_tdata,
  output logic        m_ctrl_axis_tlast,
  output logic [7:0]  m_ctrl_axis_tkeep,
  output logic        m_ctrl_axis_tuser,
  output logic        m_data_axis_tvalid,
  output logic [63:0] m_data_axis_tdata,
  output logic        m_data_axis_tlast,
  output logic [7:0]  m_data_axis_tkeep,
  output logic        m_data_axis_tuser,
  input  logic        m_data_axis_tready,
  output logic        m_forward_axis_tvalid,
  output logic [63:0] m_forward_axis_tdata,
  output logic        m_forward_axis_tlast,
  output logic [7:0]  m_forward_axis_tkeep,
  output logic        m_forward_axis_tuser,
  input  logic        m_forward_axis_tready,
  output logic [15:0] o_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_OUT0, S_OUT1, S_PASS, S_DROP
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE, SEL_CTRL, SEL_DATA, SEL_FWD
  } sel_t;

  // Header fields: EtherType is big-endian on the wire, byte 12 = beat1[39:32].
  function automatic sel_t classify(input logic [15:0] eth_type, input logic [7:0] type_byte);
    sel_t s;
    s = SEL_NONE;
    if (eth_type == P_ETH_TYPE) begin
      if (type_byte == P_TYPE_CTRL)      s = SEL_CTRL;
      else if (type_byte == P_TYPE_DATA) s = SEL_DATA;
      else if (type_byte == P_TYPE_FWD)  s = SEL_FWD;
    end
    return s;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  sel_t        sel_q, sel_d;
  sel_t        hdr_sel;
  logic [63:0] h0_q;
  logic [63:0] h1_q;
  logic        h1_last_q;
  logic [7:0]  h1_keep_q;
  logic        h1_user_q;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        rx_rdy;
  logic        rx_acc;
  logic        ld_h0, ld_h1, drop_evt;
  logic        sel_rdy;
  logic        out_vld;
  logic [63:0] out_data;
  logic        out_last;
  logic [7:0]  out_keep;
  logic        out_user;

  assign hdr_sel = classify({s_rx_axis_tdata[39:32], s_rx_axis_tdata[47:40]},
                            s_rx_axis_tdata[55:48]);
  assign rx_acc  = s_rx_axis_tvalid & rx_rdy;

  // Downstream ready of whichever port the current frame is steered to.
  always_comb begin
    sel_rdy = 1'b0;
    case (sel_q)
      SEL_CTRL: sel_rdy = 1'b1;
      SEL_DATA: sel_rdy = m_data_axis_tready;
      SEL_FWD:  sel_rdy = m_forward_axis_tready;
      default:  sel_rdy = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rx_rdy   = 1'b0;
    ld_h0    = 1'b0;
    ld_h1    = 1'b0;
    drop_evt = 1'b0;
    out_vld  = 1'b0;
    out_data = '0;
    out_last = 1'b0;
    out_keep = '0;
    out_user = 1'b0;
    case (state_q)
      S_IDLE: begin
        rx_rdy = 1'b1;
        if (rx_acc) begin
          ld_h0 = 1'b1;
          if (s_rx_axis_tlast) drop_evt = 1'b1;
          else                 state_d  = S_HDR;
        end
      end
      S_HDR: begin
        rx_rdy = 1'b1;
        if (rx_acc) begin
          ld_h1 = 1'b1;
          sel_d = hdr_sel;
          if (hdr_sel == SEL_NONE) begin
            drop_evt = 1'b1;
            state_d  = s_rx_axis_tlast ? S_IDLE : S_DROP;
          end else begin
            state_d = S_OUT0;
          end
        end
      end
      S_OUT0: begin
        out_vld  = 1'b1;
        out_data = h0_q;
        out_keep = 8'hFF;
        if (sel_rdy) state_d = S_OUT1;
      end
      S_OUT1: begin
        out_vld  = 1'b1;
        out_data = h1_q;
        out_last = h1_last_q;
        out_keep = h1_keep_q;
        out_user = h1_user_q;
        if (sel_rdy) state_d = h1_last_q ? S_IDLE : S_PASS;
      end
      S_PASS: begin
        // RX ready mirrors the selected sink so backpressure reaches the MAC.
        rx_rdy   = sel_rdy;
        out_vld  = s_rx_axis_tvalid;
        out_data = s_rx_axis_tdata;
        out_last = s_rx_axis_tlast;
        out_keep = s_rx_axis_tkeep;
        out_user = s_rx_axis_tuser;
        if (rx_acc && s_rx_axis_tlast) state_d = S_IDLE;
      end
      S_DROP: begin
        rx_rdy = 1'b1;
        if (rx_acc && s_rx_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign drop_cnt_d = drop_evt ? sat_inc(drop_cnt_q) : drop_cnt_q;

  always_ff @(posedge i_data_clk or posedge i_data_rst) begin
    if (i_data_rst) begin
      state_q    <= S_IDLE;
      sel_q      <= SEL_NONE;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Header holding registers carry data only and need no reset.
  always_ff @(posedge i_data_clk) begin
    if (ld_h0) h0_q <= s_rx_axis_tdata;
    if (ld_h1) begin
      h1_q      <= s_rx_axis_tdata;
      h1_last_q <= s_rx_axis_tlast;
      h1_keep_q <= s_rx_axis_tkeep;
      h1_user_q <= s_rx_axis_tuser;
    end
  end

  // RX ready is forced low while reset is held.
  assign s_rx_axis_tready = rx_rdy & ~i_data_rst;
  assign o_drop_cnt       = drop_cnt_q;

  // Non-selected ports stay fully zero; IDLE/HDR/DROP already drive zeros.
  logic is_ctrl, is_data, is_fwd;
  assign is_ctrl = (sel_q == SEL_CTRL);
  assign is_data = (sel_q == SEL_DATA);
  assign is_fwd  = (sel_q == SEL_FWD);

  assign m_ctrl_axis_tvalid    = out_vld & is_ctrl;
  assign m_ctrl_axis_tdata     = is_ctrl ? out_data : '0;
  assign m_ctrl_axis_tlast     = out_last & is_ctrl;
  assign m_ctrl_axis_tkeep     = is_ctrl ? out_keep : '0;
  assign m_ctrl_axis_tuser     = out_user & is_ctrl;

  assign m_data_axis_tvalid    = out_vld & is_data;
  assign m_data_axis_tdata     = is_data ? out_data : '0;
  assign m_data_axis_tlast     = out_last & is_data;
  assign m_data_axis_tkeep     = is_data ? out_keep : '0;
  assign m_data_axis_tuser     = out_user & is_data;

  assign m_forward_axis_tvalid = out_vld & is_fwd;
  assign m_forward_axis_tdata  = is_fwd ? out_data : '0;
  assign m_forward_axis_tlast  = out_last & is_fwd;
  assign m_forward_axis_tkeep  = is_fwd ? out_keep : '0;
  assign m_forward_axis_tuser  = out_user & is_fwd;

endmodule
